// File: rtl/xor_fold_pipe.sv
// xor_fold_pipe: per-channel XOR fold of IN_W-bit words down to OUT_W bits,
// with a one-cycle registered result and valid/ready handshakes on both sides.
// Build option: define XOR_FOLD_ACC_EN to add frame-accumulate mode
// (mode = 1 folds all beats up to in_last into one result, out_cnt counts beats).
// Without it the block folds every beat independently and ignores mode/in_last.
module xor_fold_pipe #(
    parameter int IN_W  = 64,
    parameter int OUT_W = 32,
    parameter int CH    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CH*IN_W-1:0]    in_data,
    input  logic                  in_last,
    input  logic                  mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CH*OUT_W-1:0]   out_data,
    output logic [7:0]            out_cnt
);

    localparam int FOLD = IN_W / OUT_W;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC  = 2'd1;
    localparam logic [1:0] OUT  = 2'd2;

    logic [1:0]          state;
    logic [CH*OUT_W-1:0] fold;
    logic                accept;

    // The result register frees up in the same cycle it is consumed, so
    // in_ready depends only on state and out_ready (never on in_valid).
    assign in_ready  = (state != OUT) || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == OUT);

    // XOR all OUT_W-wide slices of each channel's input word together.
    always_comb begin
        fold = '0;
        for (int c = 0; c < CH; c++) begin
            for (int k = 0; k < FOLD; k++) begin
                fold[c*OUT_W +: OUT_W] = fold[c*OUT_W +: OUT_W]
                                       ^ in_data[c*IN_W + k*OUT_W +: OUT_W];
            end
        end
    end

`ifdef XOR_FOLD_ACC_EN

    logic                frame_mode;
    logic [CH*OUT_W-1:0] acc;
    logic [7:0]          cnt;

    logic                fresh;
    logic                eff_mode;
    logic                term;
    logic [CH*OUT_W-1:0] acc_in;
    logic [CH*OUT_W-1:0] acc_next;
    logic [7:0]          cnt_next;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // A beat arriving in IDLE, or in OUT while the result drains, opens a new
    // frame: it samples mode and starts from an empty accumulator.
    assign fresh    = (state != ACC);
    assign eff_mode = fresh ? mode : frame_mode;
    assign term     = !eff_mode || in_last;
    assign acc_in   = fresh ? '0 : acc;
    assign acc_next = acc_in ^ fold;
    assign cnt_next = sat_inc(fresh ? 8'd0 : cnt);

    // Frame FSM: fold into acc until the terminating beat, then present result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            frame_mode <= 1'b0;
            acc        <= '0;
            cnt        <= '0;
            out_data   <= '0;
            out_cnt    <= '0;
        end else if (accept) begin
            frame_mode <= eff_mode;
            if (term) begin
                state    <= OUT;
                out_data <= acc_next;
                out_cnt  <= cnt_next;
                acc      <= '0;
                cnt      <= '0;
            end else begin
                state <= ACC;
                acc   <= acc_next;
                cnt   <= cnt_next;
            end
        end else if ((state == OUT) && out_ready) begin
            state <= IDLE;
        end
    end

`else

    // Frame controls have no meaning when only per-beat folding exists.
    logic unused_frame_ctrl;
    assign unused_frame_ctrl = mode ^ in_last;

    // Per-beat only: every accepted beat becomes one result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            out_data <= '0;
            out_cnt  <= '0;
        end else if (accept) begin
            state    <= OUT;
            out_data <= fold;
            out_cnt  <= 8'd1;
        end else if ((state == OUT) && out_ready) begin
            state <= IDLE;
        end
    end

`endif

endmodule

// File: tb/tb_xor_fold_pipe.sv
// Testbench for xor_fold_pipe (IN_W=64, OUT_W=32, CH=2). Expected results come
// from a frame-level reference: fold each beat, XOR beats of a frame together,
// count beats with saturation. Follows XOR_FOLD_ACC_EN like the design.
module tb_xor_fold_pipe;

    localparam int IN_W  = 64;
    localparam int OUT_W = 32;
    localparam int CH    = 2;
    localparam int DIN   = CH * IN_W;
    localparam int DOUT  = CH * OUT_W;

`ifdef XOR_FOLD_ACC_EN
    localparam bit ACC_BUILD = 1'b1;
`else
    localparam bit ACC_BUILD = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [DIN-1:0]  in_data;
    logic            in_last;
    logic            mode;
    logic            out_valid;
    logic            out_ready;
    logic [DOUT-1:0] out_data;
    logic [7:0]      out_cnt;

    int checks = 0;
    int errors = 0;

    xor_fold_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .CH(CH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_cnt   (out_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference fold: XOR of the OUT_W-bit slices of each channel word.
    function automatic logic [DOUT-1:0] fold_all(input logic [DIN-1:0] d);
        logic [DOUT-1:0]  r;
        logic [IN_W-1:0]  w;
        logic [OUT_W-1:0] f;
        r = '0;
        for (int c = 0; c < CH; c++) begin
            w = d[c*IN_W +: IN_W];
            f = '0;
            for (int k = 0; k < IN_W / OUT_W; k++) begin
                f = f ^ w[OUT_W-1:0];
                w = w >> OUT_W;
            end
            r[c*OUT_W +: OUT_W] = f;
        end
        return r;
    endfunction

    function automatic logic [DIN-1:0] rnd();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [63:0] sat_cnt(input int n);
        return (n > 255) ? 64'd255 : 64'(n);
    endfunction

    // Offer one beat at a falling edge, let it be taken at the rising edge,
    // return at the next falling edge with the beat still driven.
    task automatic beat(input logic [DIN-1:0] d, input bit last, input bit md);
        in_valid  = 1'b1;
        in_data   = d;
        in_last   = last;
        mode      = md;
        out_ready = 1'b1;
        #1;
        chk("in_ready_offer", 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Back-to-back frame of n beats; mode toggles randomly after the first beat
    // of an accumulate frame and must be ignored.
    task automatic stream(input int n, input bit md, input bit zeros, input string tag);
        logic [DOUT-1:0] x;
        logic [DIN-1:0]  d;
        int              c;
        bit              term;
        bit              m;
        x = '0;
        c = 0;
        for (int i = 0; i < n; i++) begin
            d = zeros ? '0 : rnd();
            m = (i == 0 || !md) ? md : 1'($urandom_range(0, 1));
            beat(d, i == n - 1, m);
            x = x ^ fold_all(d);
            c++;
            term = !ACC_BUILD || !md || (i == n - 1);
            chk({tag, "_valid"}, 64'(out_valid), 64'(term));
            if (term) begin
                chk({tag, "_data"}, 64'(out_data), 64'(x));
                chk({tag, "_cnt"}, 64'(out_cnt), sat_cnt(c));
                x = '0;
                c = 0;
            end
        end
        idle_cycle();
        chk({tag, "_drained"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        logic [DIN-1:0]  d1;
        logic [DIN-1:0]  d2;
        logic [DOUT-1:0] held;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        mode      = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_cnt", 64'(out_cnt), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        chk("post_rst_out_valid", 64'(out_valid), 64'd0);

        // Per-beat directed vector
        beat({64'h12345678_12345678, 64'hFFFF0000_0000FFFF}, 1'b0, 1'b0);
        chk("pb_dir_valid", 64'(out_valid), 64'd1);
        chk("pb_dir_data", 64'(out_data), {32'h00000000, 32'hFFFFFFFF});
        chk("pb_dir_cnt", 64'(out_cnt), 64'd1);
        idle_cycle();
        chk("pb_dir_drained", 64'(out_valid), 64'd0);

        // Three-beat accumulate directed vector on ch0
        beat({64'h0, 64'h00000001_00000001}, 1'b0, 1'b1);
        chk("acc3_v1", 64'(out_valid), 64'(!ACC_BUILD));
        beat({64'h0, 64'h00000002_00000002}, 1'b0, 1'b1);
        chk("acc3_v2", 64'(out_valid), 64'(!ACC_BUILD));
        beat({64'h0, 64'h00000004_00000004}, 1'b1, 1'b1);
        chk("acc3_valid", 64'(out_valid), 64'd1);
        chk("acc3_data", 64'(out_data), 64'd0);
        chk("acc3_cnt", 64'(out_cnt), ACC_BUILD ? 64'd3 : 64'd1);
        idle_cycle();

        // Backpressure in OUT, then release with a new beat for no-bubble issue
        d1 = rnd();
        d2 = rnd();
        beat(d1, 1'b0, 1'b0);
        in_data   = d2;
        out_ready = 1'b0;
        #1;
        chk("bp_in_ready0", 64'(in_ready), 64'd0);
        chk("bp_valid0", 64'(out_valid), 64'd1);
        held = fold_all(d1);
        chk("bp_data0", 64'(out_data), 64'(held));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_hold_in_ready", 64'(in_ready), 64'd0);
            chk("bp_hold_valid", 64'(out_valid), 64'd1);
            chk("bp_hold_data", 64'(out_data), 64'(held));
            chk("bp_hold_cnt", 64'(out_cnt), 64'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        chk("bp_next_valid", 64'(out_valid), 64'd1);
        chk("bp_next_data", 64'(out_data), 64'(fold_all(d2)));
        idle_cycle();
        chk("bp_drained", 64'(out_valid), 64'd0);

        // Randomized frames against the frame-level reference
        stream(6, 1'b0, 1'b0, "pb_rand");
        stream(5, 1'b1, 1'b0, "acc_rand");
        stream(1, 1'b1, 1'b0, "acc_single");
        stream(4, 1'b1, 1'b0, "acc_rand2");
        stream(300, 1'b1, 1'b1, "zero300");
        stream(270, 1'b1, 1'b0, "rand270");

        // Reset in the middle of an accumulate frame
        beat(rnd(), 1'b0, 1'b1);
        beat(rnd(), 1'b0, 1'b1);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_cnt", 64'(out_cnt), 64'd0);
        chk("midrst_data", 64'(out_data), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_rel_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_rel_valid", 64'(out_valid), 64'd0);
        d1 = rnd();
        @(negedge clk);
        beat(d1, 1'b1, 1'b1);
        chk("midrst_frame_valid", 64'(out_valid), 64'd1);
        chk("midrst_frame_data", 64'(out_data), 64'(fold_all(d1)));
        chk("midrst_frame_cnt", 64'(out_cnt), 64'd1);
        idle_cycle();

        // Reset while a result is held under backpressure
        beat(rnd(), 1'b0, 1'b0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("outrst_pre_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("outrst_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("outrst_no_stale", 64'(out_valid), 64'd0);
            chk("outrst_in_ready", 64'(in_ready), 64'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/xor_fold_pipe.md
XOR_FOLD_PIPE -- requirements
Module: xor_fold_pipe

Interface
REQ-001 SHALL have parameter IN_W, default 64, meaning input word width per channel.
REQ-002 SHALL have parameter OUT_W, default 32, meaning folded output width per channel; IN_W SHALL be an integer multiple of OUT_W, with FOLD = IN_W/OUT_W >= 2.
REQ-003 SHALL have parameter CH, default 2, meaning number of independent channels.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have port in_valid, input, 1, meaning an input beat is offered.
REQ-007 SHALL have port in_ready, output, 1, meaning the block accepts the beat this cycle.
REQ-008 SHALL have port in_data, input, CH*IN_W, meaning channel c occupies bits [c*IN_W +: IN_W].
REQ-009 SHALL have port in_last, input, 1, meaning the last beat of a frame.
REQ-010 SHALL have port mode, input, 1, meaning 0 = per-beat fold and 1 = frame accumulate.
REQ-011 SHALL have port out_valid, output, 1, meaning a result is presented.
REQ-012 SHALL have port out_ready, input, 1, meaning the downstream accepts the result.
REQ-013 SHALL have port out_data, output, CH*OUT_W, meaning channel c occupies bits [c*OUT_W +: OUT_W].
REQ-014 SHALL have port out_cnt, output, 8, meaning the number of beats folded into out_data, saturating at 255.

Function
REQ-015 fold(c) SHALL be the XOR over k=0..FOLD-1 of in_data[c*IN_W + k*OUT_W +: OUT_W]; channels SHALL be independent.
REQ-016 A beat SHALL be accepted when in_valid && in_ready.
REQ-017 in_ready SHALL be (state != OUT) || out_ready, with no combinational path from in_valid.
REQ-018 The FSM SHALL have states IDLE (no partial frame), ACC (partial frame held), and OUT (result presented).
REQ-019 On an accepted beat in IDLE, the block SHALL sample mode into frame_mode; frame_mode SHALL stay fixed until the frame ends, and mid-frame mode changes SHALL be ignored.
REQ-020 In per-beat mode (frame_mode = 0), every accepted beat SHALL be treated as last, so out_data = fold, out_cnt = 1, and in_last SHALL be ignored.
REQ-021 In accumulate mode, an accepted beat without in_last SHALL set acc ^= fold, increment the count, and move to ACC.
REQ-022 In accumulate mode, an accepted beat with in_last SHALL set out_data = acc ^ fold, clear acc, and move to OUT.
REQ-023 Latency from accepting the last beat to out_valid SHALL be exactly 1 cycle.
REQ-024 In OUT with out_ready = 1, the state SHALL move to IDLE.
REQ-025 In OUT with out_ready = 1, a simultaneously accepted beat SHALL be processed as if in IDLE, giving 1 result per cycle with no bubble.
REQ-026 In OUT with out_ready = 0, out_data, out_cnt and out_valid SHALL hold stable and in_ready SHALL be 0.
REQ-027 out_cnt SHALL saturate at 255, while acc keeps folding beyond it.
REQ-028 A single-beat frame in accumulate mode (in_last on the first beat) SHALL give out_data = fold and out_cnt = 1.

Reset
REQ-029 rst_n low SHALL asynchronously force state = IDLE, out_valid = 0, out_data = 0, out_cnt = 0, acc = 0 and frame_mode = 0.
REQ-030 After reset, in_ready SHALL be 1.
REQ-031 Reset mid-frame or in OUT SHALL discard the partial frame or pending result, and no stale output SHALL appear after release.

Configuration
REQ-032 The macro XOR_FOLD_ACC_EN, when defined, SHALL compile in accumulate mode, the ACC state, the acc register and out_cnt counting.
REQ-033 Without XOR_FOLD_ACC_EN, mode and in_last SHALL be ignored and the block SHALL behave as per-beat only (IDLE/OUT), with out_cnt = 1 whenever out_valid and 0 from reset.

Verification (IN_W=64, OUT_W=32, CH=2)
REQ-034 mode=0; ch0 = 64'hFFFF0000_0000FFFF, ch1 = 64'h12345678_12345678 -> next cycle out_valid=1, ch0=32'hFFFFFFFF, ch1=32'h00000000, out_cnt=1.
REQ-035 mode=1 with 3 beats on ch0 (64'h1_00000001, 64'h2_00000002, 64'h4_00000004 with in_last) -> a single result, ch0=32'h00000000, out_cnt=3.
REQ-036 Hold out_ready=0 for 5 cycles while in OUT -> in_ready=0 and out_data stable; then out_ready=1 together with a new beat -> the next result appears the following cycle with no bubble.
REQ-037 Drop rst_n for 1 cycle after 2 accumulate beats without in_last -> out_valid=0; a following 1-beat frame returns only its own fold with out_cnt=1.
REQ-038 Send a 300-beat accumulate frame of all-zero data -> out_cnt=255 and ch0=0; build without XOR_FOLD_ACC_EN -> every beat yields one result with out_cnt=1.
